// File: rtl/playlist_pkg.sv
// Shared types and helpers for the playlist sequencing controller.
package playlist_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, GAP} state_t;

  // Button bit positions; a lower index means a higher priority.
  localparam int NUM_BTN   = 4;
  localparam int BTN_STOP  = 0;
  localparam int BTN_START = 1;
  localparam int BTN_NEXT  = 2;
  localparam int BTN_PRE   = 3;

  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // Keep only the highest-priority (lowest-index) press.
  function automatic logic [NUM_BTN-1:0] prio_pick(input logic [NUM_BTN-1:0] p);
    return p & (~p + NUM_BTN'(1));
  endfunction

endpackage

// File: rtl/playlist_ctl_btn_edge.sv
// Rising-edge detector for level buttons; history resets to 1 so a button
// held through reset does not register as a press.
module btn_edge #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] press
);

  logic [W-1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) hist <= '1;
    else     hist <= din;
  end

  assign press = din & ~hist;

endmodule

// File: rtl/playlist_ctl.sv
// Play/pause/track sequencer: button and end-of-song handling, inter-song gap,
// one-hot play enables, restart pulse, track digit and elapsed-seconds count.
module playlist_ctl
  import playlist_pkg::*;
#(
  parameter int CLK_FRE    = 50_000_000,
  parameter int NUM_SONGS  = 4,
  parameter int GAP_CYCLES = 1000,
  parameter int AUTO_NEXT  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        next_song,
  input  logic                        pre_song,
  input  logic [NUM_SONGS-1:0]        song_done,
  output logic [NUM_SONGS-1:0]        play_en,
  output logic                        song_rst,
  output logic [clog2(NUM_SONGS)-1:0] song_sel,
  output logic                        start_stop,
  output logic [3:0]                  o_hex_Data,
  output logic [7:0]                  sec_cnt
);

  localparam int SW = clog2(NUM_SONGS);
  localparam int TW = clog2(CLK_FRE);
  localparam int GW = clog2(GAP_CYCLES + 1);

  logic [NUM_BTN-1:0] btn, press, act;
  state_t             state, nstate;
  logic [SW-1:0]      nsel, sel_inc, sel_dec;
  logic               nrst, done;
  logic [GW-1:0]      gap_cnt;
  logic [TW-1:0]      tick;

  assign btn[BTN_STOP]  = stop;
  assign btn[BTN_START] = start;
  assign btn[BTN_NEXT]  = next_song;
  assign btn[BTN_PRE]   = pre_song;

  btn_edge #(.W(NUM_BTN)) u_btn (
    .clk  (clk),
    .rst  (rst),
    .din  (btn),
    .press(press)
  );

  assign act     = prio_pick(press);
  assign sel_inc = (song_sel == SW'(NUM_SONGS - 1)) ? '0 : song_sel + 1'b1;
  assign sel_dec = (song_sel == '0) ? SW'(NUM_SONGS - 1) : song_sel - 1'b1;
  assign done    = song_done[song_sel];

  always_comb begin
    nstate = state;
    nsel   = song_sel;
    nrst   = 1'b0;
    case (state)
      IDLE: begin
        if (act[BTN_START]) begin
          nstate = PLAY;
          nrst   = 1'b1;
        end else if (act[BTN_NEXT]) begin
          nsel = sel_inc;
          nrst = 1'b1;
        end else if (act[BTN_PRE]) begin
          nsel = sel_dec;
          nrst = 1'b1;
        end
      end
      PLAY: begin
        if (act[BTN_STOP]) begin
          nstate = PAUSE;
        end else if (act[BTN_NEXT] || act[BTN_PRE]) begin
          nsel   = act[BTN_NEXT] ? sel_inc : sel_dec;
          nrst   = 1'b1;
          nstate = GAP;
        end else if (done) begin
          nrst = 1'b1;
          if (AUTO_NEXT != 0) begin
            nsel   = sel_inc;
            nstate = GAP;
          end else begin
            nstate = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (act[BTN_START]) begin
          nstate = PLAY;
        end else if (act[BTN_NEXT] || act[BTN_PRE]) begin
          nsel = act[BTN_NEXT] ? sel_inc : sel_dec;
          nrst = 1'b1;
        end
      end
      GAP: begin
        if (act[BTN_STOP]) begin
          nstate = PAUSE;
        end else if (act[BTN_NEXT] || act[BTN_PRE]) begin
          nsel = act[BTN_NEXT] ? sel_inc : sel_dec;
          nrst = 1'b1;
        end else if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          nstate = PLAY;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      song_sel   <= '0;
      play_en    <= '0;
      song_rst   <= 1'b0;
      start_stop <= 1'b0;
      o_hex_Data <= 4'd1;
      sec_cnt    <= 8'd0;
      tick       <= '0;
      gap_cnt    <= '0;
    end else begin
      state      <= nstate;
      song_sel   <= nsel;
      song_rst   <= nrst;
      play_en    <= (nstate == PLAY) ? (NUM_SONGS'(1) << nsel) : '0;
      start_stop <= (nstate == PLAY) || (nstate == GAP);
      o_hex_Data <= 4'(nsel) + 4'd1;
      // A restart inside GAP reopens the full gap window.
      if (nrst || state != GAP) gap_cnt <= '0;
      else                      gap_cnt <= gap_cnt + 1'b1;
      if (nrst) begin
        tick    <= '0;
        sec_cnt <= 8'd0;
      end else if (state == PLAY) begin
        if (tick == TW'(CLK_FRE - 1)) begin
          tick <= '0;
          if (sec_cnt != 8'hFF) sec_cnt <= sec_cnt + 8'd1;
        end else begin
          tick <= tick + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_playlist_ctl.sv
// Directed bench for playlist_ctl (CLK_FRE=10, GAP_CYCLES=4, NUM_SONGS=4),
// with a second instance built with AUTO_NEXT=0.
module tb_playlist_ctl;

  logic       clk = 1'b0;
  logic       rst, start, stop, next_song, pre_song;
  logic [3:0] song_done, song_done0;
  logic [3:0] play_en, an_play_en;
  logic       song_rst, an_song_rst, start_stop, an_start_stop;
  logic [1:0] song_sel, an_song_sel;
  logic [3:0] o_hex_Data, an_hex;
  logic [7:0] sec_cnt, an_sec_cnt;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  playlist_ctl #(.CLK_FRE(10), .NUM_SONGS(4), .GAP_CYCLES(4), .AUTO_NEXT(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .next_song(next_song),
    .pre_song(pre_song), .song_done(song_done), .play_en(play_en), .song_rst(song_rst),
    .song_sel(song_sel), .start_stop(start_stop), .o_hex_Data(o_hex_Data), .sec_cnt(sec_cnt)
  );

  playlist_ctl #(.CLK_FRE(10), .NUM_SONGS(4), .GAP_CYCLES(4), .AUTO_NEXT(0)) u_an0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .next_song(next_song),
    .pre_song(pre_song), .song_done(song_done0), .play_en(an_play_en), .song_rst(an_song_rst),
    .song_sel(an_song_sel), .start_stop(an_start_stop), .o_hex_Data(an_hex), .sec_cnt(an_sec_cnt)
  );

  // Advance n edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(1);
    tests++; if (play_en !== 4'b0000) begin failed++; $display("FAIL reset_play_en got %b want 0000", play_en); end
    tests++; if (song_rst !== 1'b0) begin failed++; $display("FAIL reset_song_rst got %b want 0", song_rst); end
    tests++; if (start_stop !== 1'b0) begin failed++; $display("FAIL reset_start_stop got %b want 0", start_stop); end
    tests++; if (song_sel !== 2'd0) begin failed++; $display("FAIL reset_song_sel got %0d want 0", song_sel); end
    tests++; if (o_hex_Data !== 4'd1) begin failed++; $display("FAIL reset_hex got %0d want 1", o_hex_Data); end
    tests++; if (sec_cnt !== 8'd0) begin failed++; $display("FAIL reset_sec_cnt got %0d want 0", sec_cnt); end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_start;
    start = 1'b1; step(1); start = 1'b0;
    tests++; if (play_en !== 4'b0001) begin failed++; $display("FAIL start_play_en got %b want 0001", play_en); end
    tests++; if (song_rst !== 1'b1) begin failed++; $display("FAIL start_song_rst got %b want 1", song_rst); end
    tests++; if (start_stop !== 1'b1) begin failed++; $display("FAIL start_led got %b want 1", start_stop); end
    tests++; if (o_hex_Data !== 4'd1) begin failed++; $display("FAIL start_hex got %0d want 1", o_hex_Data); end
    step(1);
    tests++; if (song_rst !== 1'b0) begin failed++; $display("FAIL start_rst_single got %b want 0", song_rst); end
    step(28);
    tests++; if (sec_cnt !== 8'd2) begin failed++; $display("FAIL start_sec29 got %0d want 2", sec_cnt); end
    step(1);
    tests++; if (sec_cnt !== 8'd3) begin failed++; $display("FAIL start_sec30 got %0d want 3", sec_cnt); end
  endtask

  task automatic test_next_pre;
    next_song = 1'b1; step(1); next_song = 1'b0;
    tests++; if (song_sel !== 2'd1) begin failed++; $display("FAIL next_sel got %0d want 1", song_sel); end
    tests++; if (o_hex_Data !== 4'd2) begin failed++; $display("FAIL next_hex got %0d want 2", o_hex_Data); end
    tests++; if (song_rst !== 1'b1) begin failed++; $display("FAIL next_song_rst got %b want 1", song_rst); end
    tests++; if (sec_cnt !== 8'd0) begin failed++; $display("FAIL next_sec got %0d want 0", sec_cnt); end
    tests++; if (start_stop !== 1'b1) begin failed++; $display("FAIL next_gap_led got %b want 1", start_stop); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (play_en !== 4'b0000) begin failed++; $display("FAIL next_gap%0d got %b want 0000", i, play_en); end
      step(1);
    end
    tests++; if (play_en !== 4'b0010) begin failed++; $display("FAIL next_after_gap got %b want 0010", play_en); end
    pre_song = 1'b1; step(1); pre_song = 1'b0;
    tests++; if (song_sel !== 2'd0) begin failed++; $display("FAIL pre1_sel got %0d want 0", song_sel); end
    step(4);
    tests++; if (play_en !== 4'b0001) begin failed++; $display("FAIL pre1_play got %b want 0001", play_en); end
    pre_song = 1'b1; step(1); pre_song = 1'b0;
    tests++; if (song_sel !== 2'd3) begin failed++; $display("FAIL pre2_wrap got %0d want 3", song_sel); end
    step(4);
    tests++; if (play_en !== 4'b1000) begin failed++; $display("FAIL pre2_play got %b want 1000", play_en); end
    pre_song = 1'b1; step(1); pre_song = 1'b0;
    tests++; if (song_sel !== 2'd2) begin failed++; $display("FAIL pre3_sel got %0d want 2", song_sel); end
    step(4);
    tests++; if (play_en !== 4'b0100) begin failed++; $display("FAIL pre3_play got %b want 0100", play_en); end
    tests++; if (o_hex_Data !== 4'd3) begin failed++; $display("FAIL pre3_hex got %0d want 3", o_hex_Data); end
  endtask

  task automatic test_stop_resume;
    step(50);
    tests++; if (sec_cnt !== 8'd5) begin failed++; $display("FAIL pause_pre_sec got %0d want 5", sec_cnt); end
    step(3);
    stop = 1'b1; step(1); stop = 1'b0;
    tests++; if (play_en !== 4'b0000) begin failed++; $display("FAIL pause_play_en got %b want 0000", play_en); end
    tests++; if (start_stop !== 1'b0) begin failed++; $display("FAIL pause_led got %b want 0", start_stop); end
    tests++; if (song_rst !== 1'b0) begin failed++; $display("FAIL pause_song_rst got %b want 0", song_rst); end
    step(20);
    tests++; if (sec_cnt !== 8'd5) begin failed++; $display("FAIL pause_sec_hold got %0d want 5", sec_cnt); end
    start = 1'b1; step(1); start = 1'b0;
    tests++; if (play_en !== 4'b0100) begin failed++; $display("FAIL resume_play_en got %b want 0100", play_en); end
    tests++; if (song_rst !== 1'b0) begin failed++; $display("FAIL resume_no_rst got %b want 0", song_rst); end
    step(5);
    tests++; if (sec_cnt !== 8'd5) begin failed++; $display("FAIL resume_sec5 got %0d want 5", sec_cnt); end
    step(1);
    tests++; if (sec_cnt !== 8'd6) begin failed++; $display("FAIL resume_sec6 got %0d want 6", sec_cnt); end
  endtask

  task automatic test_song_done;
    next_song = 1'b1; step(1); next_song = 1'b0;
    step(4);
    tests++; if (play_en !== 4'b1000) begin failed++; $display("FAIL done_setup got %b want 1000", play_en); end
    song_done = 4'b1000; step(1); song_done = 4'b0000;
    tests++; if (song_sel !== 2'd0) begin failed++; $display("FAIL done_wrap got %0d want 0", song_sel); end
    tests++; if (song_rst !== 1'b1) begin failed++; $display("FAIL done_rst got %b want 1", song_rst); end
    step(3);
    tests++; if (play_en !== 4'b0000) begin failed++; $display("FAIL done_gap got %b want 0000", play_en); end
    step(1);
    tests++; if (play_en !== 4'b0001) begin failed++; $display("FAIL done_play got %b want 0001", play_en); end
    song_done = 4'b0010; step(1); song_done = 4'b0000;
    tests++; if (play_en !== 4'b0001) begin failed++; $display("FAIL done_other_play got %b want 0001", play_en); end
    tests++; if (song_rst !== 1'b0) begin failed++; $display("FAIL done_other_rst got %b want 0", song_rst); end
  endtask

  task automatic test_auto_next0;
    rst = 1'b1; step(1); rst = 1'b0; step(1);
    start = 1'b1; step(1); start = 1'b0;
    pre_song = 1'b1; step(1); pre_song = 1'b0;
    step(4);
    tests++; if (an_play_en !== 4'b1000) begin failed++; $display("FAIL an0_setup got %b want 1000", an_play_en); end
    song_done0 = 4'b1000; step(1); song_done0 = 4'b0000;
    tests++; if (an_song_rst !== 1'b1) begin failed++; $display("FAIL an0_rst got %b want 1", an_song_rst); end
    tests++; if (an_start_stop !== 1'b0) begin failed++; $display("FAIL an0_pause_led got %b want 0", an_start_stop); end
    tests++; if (an_song_sel !== 2'd3) begin failed++; $display("FAIL an0_sel got %0d want 3", an_song_sel); end
    step(7);
    tests++; if (an_play_en !== 4'b0000) begin failed++; $display("FAIL an0_stays_paused got %b want 0000", an_play_en); end
    start = 1'b1; step(1); start = 1'b0;
    tests++; if (an_play_en !== 4'b1000) begin failed++; $display("FAIL an0_resume got %b want 1000", an_play_en); end
  endtask

  task automatic test_priority;
    stop = 1'b1; start = 1'b1; next_song = 1'b1; step(1);
    stop = 1'b0; start = 1'b0; next_song = 1'b0;
    tests++; if (play_en !== 4'b0000) begin failed++; $display("FAIL prio_play_en got %b want 0000", play_en); end
    tests++; if (start_stop !== 1'b0) begin failed++; $display("FAIL prio_led got %b want 0", start_stop); end
    tests++; if (song_sel !== 2'd3) begin failed++; $display("FAIL prio_sel got %0d want 3", song_sel); end
    tests++; if (song_rst !== 1'b0) begin failed++; $display("FAIL prio_rst got %b want 0", song_rst); end
    rst = 1'b1; start = 1'b1; step(2); rst = 1'b0;
    step(3);
    tests++; if (start_stop !== 1'b0) begin failed++; $display("FAIL held_start_led got %b want 0", start_stop); end
    tests++; if (song_rst !== 1'b0) begin failed++; $display("FAIL held_start_rst got %b want 0", song_rst); end
    start = 1'b0; step(1);
    start = 1'b1; step(1); start = 1'b0;
    tests++; if (play_en !== 4'b0001) begin failed++; $display("FAIL repress_play got %b want 0001", play_en); end
  endtask

  task automatic test_gap_reset;
    next_song = 1'b1; step(1); next_song = 1'b0;
    step(1);
    rst = 1'b1; step(1); rst = 1'b0;
    tests++; if (play_en !== 4'b0000) begin failed++; $display("FAIL gaprst_play_en got %b want 0000", play_en); end
    tests++; if (song_sel !== 2'd0) begin failed++; $display("FAIL gaprst_sel got %0d want 0", song_sel); end
    tests++; if (o_hex_Data !== 4'd1) begin failed++; $display("FAIL gaprst_hex got %0d want 1", o_hex_Data); end
    tests++; if (start_stop !== 1'b0) begin failed++; $display("FAIL gaprst_led got %b want 0", start_stop); end
    tests++; if (sec_cnt !== 8'd0) begin failed++; $display("FAIL gaprst_sec got %0d want 0", sec_cnt); end
    step(6);
    tests++; if (play_en !== 4'b0000) begin failed++; $display("FAIL gaprst_abandon got %b want 0000", play_en); end
  endtask

  task automatic test_saturate;
    start = 1'b1; step(1); start = 1'b0;
    step(2549);
    tests++; if (sec_cnt !== 8'd254) begin failed++; $display("FAIL sat_254 got %0d want 254", sec_cnt); end
    step(1);
    tests++; if (sec_cnt !== 8'd255) begin failed++; $display("FAIL sat_255 got %0d want 255", sec_cnt); end
    step(200);
    tests++; if (sec_cnt !== 8'd255) begin failed++; $display("FAIL sat_hold got %0d want 255", sec_cnt); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; next_song = 1'b0; pre_song = 1'b0;
    song_done = 4'b0000; song_done0 = 4'b0000;
    step(2);
    test_reset();
    test_start();
    test_next_pre();
    test_stop_resume();
    test_song_done();
    test_auto_next0();
    test_priority();
    test_gap_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
